// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings and defaults for the SDRAM command-port arbiter.
package sdram_arbiter_pkg;

  localparam int unsigned SD_ADDR_W = 23;
  localparam int unsigned SD_DATA_W = 32;

  localparam logic [SD_ADDR_W-1:0] PRG_BASE_DEF = 23'h000000;
  localparam logic [SD_ADDR_W-1:0] CHR_BASE_DEF = 23'h008000;

  // Owner / grant encoding, also driven on the grant port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_PPU  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way CPU/PPU round-robin picker. Holds the last-served reader and
// masks a requester that was acked in the previous cycle.
module sdram_arb_rr
  import sdram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       ppu_req,
  input  logic       cpu_mask,
  input  logic       ppu_mask,
  input  logic       upd_en,
  input  logic       upd_cpu,
  output logic [1:0] pick
);

  logic last_cpu_q;
  logic last_cpu_d;
  logic cpu_ok;
  logic ppu_ok;

  // Pick a reader; on a tie the one not served last wins.
  always_comb begin
    cpu_ok     = cpu_req & ~cpu_mask;
    ppu_ok     = ppu_req & ~ppu_mask;
    last_cpu_d = last_cpu_q;
    if (upd_en) last_cpu_d = upd_cpu;
    pick = OWN_NONE;
    if (cpu_ok && ppu_ok) pick = last_cpu_q ? OWN_PPU : OWN_CPU;
    else if (cpu_ok)      pick = OWN_CPU;
    else if (ppu_ok)      pick = OWN_PPU;
  end

  // Last-served reader; starts as CPU so the PPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_cpu_q <= 1'b1;
    else        last_cpu_q <= last_cpu_d;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Sequenced, handshaked scheduler sharing the SDRAM controller command
// port between the flash loader (writes), CPU PRG and PPU CHR reads.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned          ADDR_W   = SD_ADDR_W,
  parameter int unsigned          DATA_W   = SD_DATA_W,
  parameter logic [ADDR_W-1:0]    PRG_BASE = ADDR_W'(PRG_BASE_DEF),
  parameter logic [ADDR_W-1:0]    CHR_BASE = ADDR_W'(CHR_BASE_DEF),
  parameter int unsigned          TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic [14:0]       cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              ppu_req,
  input  logic [12:0]       ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_rw,
  output logic [DATA_W-1:0] sd_data_in,
  output logic              sd_in_valid,
  input  logic              sd_busy,
  input  logic [DATA_W-1:0] sd_data_out,
  input  logic              sd_out_valid,
  output logic              timeout_err,
  output logic [1:0]        grant
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e             state_q,       state_d;
  owner_e             grant_q,       grant_d;
  logic [ADDR_W-1:0]  sd_addr_q,     sd_addr_d;
  logic               sd_rw_q,       sd_rw_d;
  logic [DATA_W-1:0]  sd_data_in_q,  sd_data_in_d;
  logic               sd_in_valid_q, sd_in_valid_d;
  logic               ld_ack_q,      ld_ack_d;
  logic               cpu_ack_q,     cpu_ack_d;
  logic               ppu_ack_q,     ppu_ack_d;
  logic [7:0]         cpu_rdata_q,   cpu_rdata_d;
  logic [7:0]         ppu_rdata_q,   ppu_rdata_d;
  logic [7:0]         rd_buf_q,      rd_buf_d;
  logic [CNT_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic [1:0] rr_pick;
  logic       rr_upd_en;
  logic       rr_upd_cpu;
  logic       unused_data_hi;

  assign unused_data_hi = ^sd_data_out[DATA_W-1:8];

  sdram_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .ppu_req  (ppu_req),
    .cpu_mask (cpu_ack_q),
    .ppu_mask (ppu_ack_q),
    .upd_en   (rr_upd_en),
    .upd_cpu  (rr_upd_cpu),
    .pick     (rr_pick)
  );

  // Next-state and next-output logic for the scheduler.
  // Read data is parked in rd_buf until DONE so the requester's rdata
  // changes in the same cycle as its ack, never earlier.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sd_addr_d     = sd_addr_q;
    sd_rw_d       = sd_rw_q;
    sd_data_in_d  = sd_data_in_q;
    sd_in_valid_d = 1'b0;
    ld_ack_d      = 1'b0;
    cpu_ack_d     = 1'b0;
    ppu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    ppu_rdata_d   = ppu_rdata_q;
    rd_buf_d      = rd_buf_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    rr_upd_en     = 1'b0;
    rr_upd_cpu    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!load_done) begin
          if (ld_req && !ld_ack_q) begin
            grant_d      = OWN_LD;
            sd_addr_d    = ld_addr;
            sd_rw_d      = 1'b1;
            sd_data_in_d = DATA_W'(ld_data);
            state_d      = ST_ISSUE;
          end
        end else if (rr_pick != OWN_NONE) begin
          grant_d      = owner_e'(rr_pick);
          sd_rw_d      = 1'b0;
          sd_data_in_d = '0;
          sd_addr_d    = (rr_pick == OWN_CPU) ? PRG_BASE + ADDR_W'(cpu_addr)
                                              : CHR_BASE + ADDR_W'(ppu_addr);
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sd_busy) begin
          sd_in_valid_d = 1'b1;
          tmo_cnt_d     = '0;
          state_d       = sd_rw_q ? ST_DONE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (sd_out_valid) begin
          rd_buf_d = sd_data_out[7:0];
          state_d  = ST_DONE;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rd_buf_d      = 8'hFF;
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        unique case (grant_q)
          OWN_LD:  ld_ack_d = 1'b1;
          OWN_CPU: begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = rd_buf_q;
            rr_upd_en   = 1'b1;
            rr_upd_cpu  = 1'b1;
          end
          OWN_PPU: begin
            ppu_ack_d   = 1'b1;
            ppu_rdata_d = rd_buf_q;
            rr_upd_en   = 1'b1;
          end
          default: ;
        endcase
        grant_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= OWN_NONE;
      sd_addr_q     <= '0;
      sd_rw_q       <= 1'b0;
      sd_data_in_q  <= '0;
      sd_in_valid_q <= 1'b0;
      ld_ack_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      ppu_ack_q     <= 1'b0;
      cpu_rdata_q   <= 8'h00;
      ppu_rdata_q   <= 8'h00;
      rd_buf_q      <= 8'h00;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sd_addr_q     <= sd_addr_d;
      sd_rw_q       <= sd_rw_d;
      sd_data_in_q  <= sd_data_in_d;
      sd_in_valid_q <= sd_in_valid_d;
      ld_ack_q      <= ld_ack_d;
      cpu_ack_q     <= cpu_ack_d;
      ppu_ack_q     <= ppu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ppu_rdata_q   <= ppu_rdata_d;
      rd_buf_q      <= rd_buf_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ld_ack      = ld_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign ppu_ack     = ppu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ppu_rdata   = ppu_rdata_q;
  assign sd_addr     = sd_addr_q;
  assign sd_rw       = sd_rw_q;
  assign sd_data_in  = sd_data_in_q;
  assign sd_in_valid = sd_in_valid_q;
  assign timeout_err = timeout_err_q;
  assign grant       = grant_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between three requesters: the flash-to-SDRAM loader (writes), the 6502 PRG fetch path (reads) and the PPU CHR fetch path (reads).
- Sits between the requesters and the sdram controller.
- Replaces the load_done-controlled mux on address and in_valid with a sequenced, handshaked scheduler that also maps requester addresses into SDRAM regions.
- Runs entirely in the 100 MHz fabric clock domain.

Parameters:
- ADDR_W, 23, SDRAM byte address width.
- DATA_W, 32, SDRAM controller data width.
- PRG_BASE, 23'h000000, SDRAM base address of the CPU (PRG) region.
- CHR_BASE, 23'h008000, SDRAM base address of the PPU (CHR) region.
- TIMEOUT, 64, maximum cycles to wait for read data (must be ≥2).

Ports:
- clk  in  1  100 MHz fabric clock.
- rst_n  in  1  asynchronous active-low reset.
- load_done  in  1  high once the flash image has been loaded into SDRAM.
- ld_req  in  1  loader write request; held until ld_ack.
- ld_addr  in  ADDR_W  loader write address (absolute).
- ld_data  in  8  loader write byte.
- ld_ack  out  1  one-cycle write-accepted pulse.
- cpu_req  in  1  CPU read request; held until cpu_ack.
- cpu_addr  in  15  CPU ROM offset.
- cpu_ack  out  1  one-cycle read-complete pulse.
- cpu_rdata  out  8  CPU read byte; valid from cpu_ack onward.
- ppu_req  in  1  PPU read request; held until ppu_ack.
- ppu_addr  in  13  PPU pattern-table offset.
- ppu_ack  out  1  one-cycle read-complete pulse.
- ppu_rdata  out  8  PPU read byte; valid from ppu_ack onward.
- sd_addr  out  ADDR_W  controller address.
- sd_rw  out  1  controller direction: 1 = write, 0 = read.
- sd_data_in  out  DATA_W  controller write data.
- sd_in_valid  out  1  one-cycle command strobe.
- sd_busy  in  1  controller busy; a command is accepted only when low.
- sd_data_out  in  DATA_W  controller read data.
- sd_out_valid  in  1  one-cycle read-data strobe.
- timeout_err  out  1  sticky read-timeout flag.
- grant  out  2  current owner: 0 none, 1 loader, 2 CPU, 3 PPU.

Behaviour:
- Reset: async on rst_n low. All outputs 0, rdata registers 8'h00, FSM IDLE, last_rd = CPU (so PPU wins the first tie).
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE, eligibility:
  - load_done=0: only ld_req is eligible; cpu_req and ppu_req are ignored (never acked).
  - load_done=1: only cpu_req and ppu_req are eligible; ld_req is ignored.
  - The requester acked in the immediately preceding cycle is masked for that one IDLE cycle, so a still-high registered req is not re-granted.
- IDLE, arbitration:
  - If both CPU and PPU are eligible, grant the one not equal to last_rd (round-robin).
  - On a grant, latch the owner, sd_addr and sd_rw, and go to ISSUE.
  - load_done is sampled only in IDLE; a change mid-operation does not abort the in-flight operation.
- Address mapping (ADDR_W-bit modular add, wrap-around ignored):
  - loader: sd_addr = ld_addr.
  - CPU: sd_addr = PRG_BASE + zero-extended cpu_addr.
  - PPU: sd_addr = CHR_BASE + zero-extended ppu_addr.
- Write data: sd_data_in = {24'b0, ld_data}, latched at grant; sd_rw=1 for the loader, 0 otherwise.
- ISSUE:
  - Wait while sd_busy=1.
  - In the first cycle sd_busy=0, pulse sd_in_valid for exactly one cycle.
  - Loader write: go to DONE.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD:
  - On sd_out_valid, latch sd_data_out[7:0] into the owner's rdata and go to DONE.
  - If the counter reaches TIMEOUT-1 without sd_out_valid, load 8'hFF into the owner's rdata, set timeout_err, and go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle; rdata becomes valid in the same cycle.
  - Update last_rd when the owner is CPU or PPU.
  - Set grant=0 and go to IDLE.
- sd_out_valid outside WAIT_RD is discarded.
- Throughput: write = 3 cycles minimum (grant→ISSUE→DONE). Read = 3 cycles + controller latency.
- timeout_err clears only on reset.
- rdata holds until the next completion for that same requester.

Decomposition:
- Shared package holds:
  - grant/owner encodings (OWN_NONE, OWN_LD, OWN_CPU, OWN_PPU);
  - FSM state encodings;
  - PRG_BASE/CHR_BASE defaults;
  - SDRAM command width constants.
- One natural sub-module: sdram_arb_rr, the combinational/registered two-way round-robin picker with the one-cycle mask. Everything else stays flat.

Test Plan:
- Reset and load:
  - Stimulus: reset; load_done=0; loader writes 8'hA5 to 23'h000123; controller busy for 3 cycles.
  - Required: sd_in_valid pulses once, after busy falls, with sd_rw=1, sd_addr=23'h000123, sd_data_in=32'h000000A5; ld_ack follows one cycle later.
- Gating:
  - Stimulus: load_done=0 with cpu_req held for 50 cycles.
  - Required: no cpu_ack, no sd_in_valid.
  - Stimulus: then load_done=1.
  - Required: CPU read issues.
- CPU read mapping:
  - Stimulus: cpu_addr=15'h7FFC; controller returns 32'h0000003C after 5 cycles.
  - Required: sd_addr=23'h007FFC; cpu_ack pulses with cpu_rdata=8'h3C.
- PPU read mapping:
  - Stimulus: ppu_addr=13'h1FFF.
  - Required: sd_addr=23'h009FFF.
- Contention:
  - Stimulus: cpu_req and ppu_req asserted together and held for 4 transactions.
  - Required: grants alternate PPU, CPU, PPU, CPU; no requester is granted twice in a row.
- Timeout:
  - Stimulus: TIMEOUT=64, controller never asserts sd_out_valid.
  - Required: ppu_ack with ppu_rdata=8'hFF, timeout_err=1 and sticky.
  - Stimulus: a late sd_out_valid arrives while in IDLE.
  - Required: it is ignored, with no spurious ack; timeout_err stays 1.
- Reset mid-operation:
  - Stimulus: rst_n low while in WAIT_RD.
  - Required: immediate IDLE, all acks 0, grant=0, timeout_err=0.
